glyph_writer: RTL and testbench

- Write-side companion to the VGA glyph display path.
- Accepts a stream of character codes from the host/keyboard logic and writes them into the glyph frame-buffer RAM through its write port.
- Uses the same descending address map as the display path: cell (row, col) lives at TOP_ADDR - (row*COLS + col).
- Maintains a text cursor and handles newline, carriage return, backspace and clear-screen. Clears the whole screen after reset.

---
 rtl/glyph_writer_if.sv | 21 ++
 rtl/glyph_writer.sv | 139 +++++++++++++
 tb/tb_glyph_writer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/glyph_writer_if.sv
// Host-to-writer code handshake plus the glyph RAM write port, bundled for glyph_writer.
// Handshake: a code transfers on a rising clock edge where charValid && charReady; charValid/charCode
// must stay stable until that edge, and charReady never waits on charValid.
interface glyph_writer_if;
  logic        charValid;
  logic [7:0]  charCode;
  logic        charReady;
  logic        wrEn;
  logic [13:0] wrAddr;
  logic [7:0]  wrData;

  modport master (
    output charValid, charCode,
    input  charReady, wrEn, wrAddr, wrData
  );

  modport slave (
    input  charValid, charCode,
    output charReady, wrEn, wrAddr, wrData
  );
endinterface

// File: rtl/glyph_writer.sv
// Writes a stream of character codes into the descending-address glyph frame buffer,
// tracking a text cursor and handling CR, LF, backspace and clear-screen.
module glyph_writer #(
  parameter int COLS     = 53,
  parameter int ROWS     = 40,
  parameter int TOP_ADDR = 16383,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic              clock,
  input  logic              resetN,
  glyph_writer_if.slave     bus,
  output logic [5:0]        cursorRow,
  output logic [5:0]        cursorCol,
  output logic              busy,
  output logic              fsmState
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [11:0] LAST_IDX = 12'(ROWS * COLS - 1);
  localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);
  localparam logic [5:0]  LAST_COL = 6'(COLS - 1);
  localparam logic [13:0] TOP      = 14'(TOP_ADDR);

  state_t      state, stateNext;
  logic [11:0] idx, idxNext;
  logic [5:0]  row, rowNext;
  logic [5:0]  col, colNext;
  logic        wrEnQ, wrEnNext;
  logic [13:0] wrAddrQ, wrAddrNext;
  logic [7:0]  wrDataQ, wrDataNext;

  logic        accept;
  logic [11:0] lin;
  logic [5:0]  rowInc;

  assign accept = (state == IDLE) && bus.charValid;
  assign lin    = ({6'd0, row} * 12'(COLS)) + {6'd0, col};
  assign rowInc = (row == LAST_ROW) ? 6'd0 : row + 6'd1;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state   <= CLEAR;
      idx     <= '0;
      row     <= '0;
      col     <= '0;
      wrEnQ   <= 1'b0;
      wrAddrQ <= '0;
      wrDataQ <= '0;
    end else begin
      state   <= stateNext;
      idx     <= idxNext;
      row     <= rowNext;
      col     <= colNext;
      wrEnQ   <= wrEnNext;
      wrAddrQ <= wrAddrNext;
      wrDataQ <= wrDataNext;
    end
  end

  always_comb begin
    stateNext  = state;
    idxNext    = idx;
    rowNext    = row;
    colNext    = col;
    wrEnNext   = 1'b0;
    wrAddrNext = wrAddrQ;
    wrDataNext = wrDataQ;
    case (state)
      CLEAR: begin
        wrEnNext   = 1'b1;
        wrAddrNext = TOP - {2'b00, idx};
        wrDataNext = BLANK;
        if (idx == LAST_IDX) begin
          idxNext   = '0;
          stateNext = IDLE;
          rowNext   = '0;
          colNext   = '0;
        end else begin
          idxNext = idx + 12'd1;
        end
      end
      default: begin
        if (accept) begin
          if (bus.charCode >= 8'h20) begin
            wrEnNext   = 1'b1;
            wrAddrNext = TOP - {2'b00, lin};
            wrDataNext = bus.charCode;
            if (col == LAST_COL) begin
              colNext = '0;
              rowNext = rowInc;
            end else begin
              colNext = col + 6'd1;
            end
          end else begin
            case (bus.charCode)
              8'h0A: begin
                colNext = '0;
                rowNext = rowInc;
              end
              8'h0D: colNext = '0;
              8'h08: begin
                // The cell before the cursor is one step up in linear order, i.e. one address higher.
                if (lin != 12'd0) begin
                  wrEnNext   = 1'b1;
                  wrAddrNext = TOP - {2'b00, lin - 12'd1};
                  wrDataNext = BLANK;
                  if (col == 6'd0) begin
                    colNext = LAST_COL;
                    rowNext = row - 6'd1;
                  end else begin
                    colNext = col - 6'd1;
                  end
                end
              end
              8'h0C: begin
                stateNext = CLEAR;
                idxNext   = '0;
                rowNext   = '0;
                colNext   = '0;
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  assign bus.charReady = (state == IDLE);
  assign bus.wrEn      = wrEnQ;
  assign bus.wrAddr    = wrAddrQ;
  assign bus.wrData    = wrDataQ;
  assign cursorRow     = row;
  assign cursorCol     = col;
  assign busy          = (state == CLEAR);
  assign fsmState      = state;

endmodule

// File: tb/tb_glyph_writer.sv
// Scoreboard bench for glyph_writer: a cursor model pushes expected RAM writes, a negedge monitor pops them.
module tb_glyph_writer;
  localparam int NCELL = 2120;

  logic       clock;
  logic       resetN;
  logic [5:0] cursorRow;
  logic [5:0] cursorCol;
  logic       busy;
  logic       fsmState;

  glyph_writer_if gw_bus ();

  glyph_writer dut (
    .clock     (clock),
    .resetN    (resetN),
    .bus       (gw_bus),
    .cursorRow (cursorRow),
    .cursorCol (cursorCol),
    .busy      (busy),
    .fsmState  (fsmState)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  logic [21:0] exp_q[$];
  int m_lin = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_clear();
    for (int i = 0; i < NCELL; i++) exp_q.push_back({14'(16383 - i), 8'h20});
    m_lin = 0;
  endtask

  // Reference cursor model kept as a single linear cell index.
  task automatic model_accept(input logic [7:0] c);
    if (c >= 8'h20) begin
      exp_q.push_back({14'(16383 - m_lin), c});
      m_lin = (m_lin + 1) % NCELL;
    end else if (c == 8'h0A) begin
      m_lin = (((m_lin / 53) + 1) % 40) * 53;
    end else if (c == 8'h0D) begin
      m_lin = (m_lin / 53) * 53;
    end else if (c == 8'h08) begin
      if (m_lin > 0) begin
        m_lin = m_lin - 1;
        exp_q.push_back({14'(16383 - m_lin), 8'h20});
      end
    end else if (c == 8'h0C) begin
      push_clear();
    end
  endtask

  always @(negedge clock) begin
    if (resetN && gw_bus.wrEn) begin
      if (exp_q.size() == 0) check("unexpected_write", {10'd0, gw_bus.wrAddr, gw_bus.wrData}, 32'hFFFF_FFFF);
      else check("write", {10'd0, gw_bus.wrAddr, gw_bus.wrData}, {10'd0, exp_q.pop_front()});
    end
  end

  task automatic send(input logic [7:0] c);
    check("ready", gw_bus.charReady, 1);
    gw_bus.charValid = 1'b1;
    gw_bus.charCode  = c;
    if (gw_bus.charReady) model_accept(c);
    @(posedge clock);
    #1;
    gw_bus.charValid = 1'b0;
  endtask

  task automatic send_n(input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) send(c);
  endtask

  task automatic check_cursor(input string tag, input int row, input int col);
    check(tag, {20'd0, cursorRow, cursorCol}, {20'd0, 6'(row), 6'(col)});
    check({tag, "_model"}, {20'd0, cursorRow, cursorCol}, {20'd0, 6'(m_lin / 53), 6'(m_lin % 53)});
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (!busy) break;
    end
    check({tag, "_done"}, busy, 0);
    repeat (2) @(negedge clock);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_ready"}, gw_bus.charReady, 1);
  endtask

  initial begin
    resetN = 1'b0;
    gw_bus.charValid = 1'b0;
    gw_bus.charCode  = 8'h00;
    repeat (3) @(posedge clock);
    #2;
    check("rst_wren", gw_bus.wrEn, 0);
    check("rst_addr", gw_bus.wrAddr, 0);
    check("rst_data", gw_bus.wrData, 0);
    check("rst_ready", gw_bus.charReady, 0);
    check("rst_busy", busy, 1);
    check("rst_state", fsmState, 1);
    check_cursor("rst_cursor", 0, 0);
    push_clear();
    @(negedge clock);
    resetN = 1'b1;
    wait_idle("boot_clear");
    check_cursor("boot_cursor", 0, 0);

    // Back-to-back printable codes.
    send(8'h41);
    send(8'h42);
    repeat (2) @(negedge clock);
    check("ab_drained", exp_q.size(), 0);
    check_cursor("ab_cursor", 0, 2);

    // Controls from (5,10).
    send(8'h0D);
    send_n(8'h0A, 5);
    send_n(8'h2E, 10);
    check_cursor("at_5_10", 5, 10);
    send(8'h0D);
    check_cursor("cr", 5, 0);
    send(8'h0A);
    check_cursor("lf", 6, 0);
    send(8'h08);
    check_cursor("bs_row_back", 5, 52);
    repeat (2) @(negedge clock);
    check("bs_drained", exp_q.size(), 0);
    send(8'h0D);
    send_n(8'h0A, 35);
    check_cursor("lf_wrap", 0, 0);
    send(8'h08);
    check_cursor("bs_origin", 0, 0);
    send(8'h07);
    check_cursor("bell_drop", 0, 0);
    repeat (2) @(negedge clock);

    // Line wrap and full-screen wrap.
    for (int i = 0; i < 52; i++) send(8'(8'h30 + $urandom_range(0, 79)));
    check_cursor("at_0_52", 0, 52);
    send(8'h5A);
    check_cursor("wrap_line", 1, 0);
    send_n(8'h0A, 38);
    for (int i = 0; i < 52; i++) send(8'(8'h20 + $urandom_range(0, 223)));
    check_cursor("at_39_52", 39, 52);
    send(8'h5A);
    check_cursor("wrap_screen", 0, 0);
    repeat (2) @(negedge clock);
    check("wrap_drained", exp_q.size(), 0);

    // Clear mid-session with a stray code offered during the clear.
    send_n(8'h0A, 3);
    send_n(8'h61, 4);
    check_cursor("at_3_4", 3, 4);
    send(8'h0C);
    check("clr_ready_drop", gw_bus.charReady, 0);
    check("clr_busy", busy, 1);
    repeat (5) @(negedge clock);
    gw_bus.charValid = 1'b1;
    gw_bus.charCode  = 8'h51;
    @(negedge clock);
    gw_bus.charValid = 1'b0;
    wait_idle("session_clear");
    check_cursor("session_cursor", 0, 0);

    // Reset partway through a clear.
    send(8'h0C);
    repeat (1000) @(posedge clock);
    #3;
    resetN = 1'b0;
    #1;
    check("midrst_wren", gw_bus.wrEn, 0);
    check("midrst_busy", busy, 1);
    check("midrst_ready", gw_bus.charReady, 0);
    exp_q.delete();
    push_clear();
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    wait_idle("restart_clear");
    check_cursor("restart_cursor", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
